// File: rtl/pdp11_uart_pkg.sv
// pdp11_uart_pkg: shared UART receiver state enum and constants; PARITY state exists only with UART_PARITY_EN
package pdp11_uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int CLK_DIV_DEFAULT = 27;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider giving a one-cycle tick every CLK_DIV clocks
module uart_baud_tick import pdp11_uart_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick  = cnt_q == W'(CLK_DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // advance the divider, wrapping on every tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled 8N1 receiver with ack/overrun handshake; UART_PARITY_EN adds an even-parity bit (8E1)
module uart_rx import pdp11_uart_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       framing_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 2);
    localparam logic [3:0] CENTRE   = 4'(OVERSAMPLE - 1);

    rx_state_e  state_q;
    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q, rx_data_q;
    logic       armed_q, framing_err_q;
    logic       rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic       tick, line, load;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign line = sync_q[1];
    assign load = tick && state_q == STOP && cnt_q == CENTRE;

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

`ifdef UART_PARITY_EN
    logic par_q, parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // handshake: a load always wins; an ack only matters while a byte is pending
    always_comb begin
        rx_valid_d = load | (rx_valid_q & ~rx_ack);
        overrun_d  = (rx_ack && rx_valid_q) ? 1'b0 : (overrun_q | (load & rx_valid_q));
    end

    // synchronizer, frame FSM and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= 2'b11;
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b0;
            rx_data_q     <= '0;
            framing_err_q <= 1'b0;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_PARITY_EN
            par_q         <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], rs232_rx};
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            if (tick) begin
                cnt_q <= cnt_q + 4'd1;
                case (state_q)
                    IDLE: begin
                        armed_q <= line;
                        if (armed_q && !line) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: if (cnt_q == MID_TICK) begin
                        state_q <= line ? IDLE : DATA;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                    DATA: if (cnt_q == CENTRE) begin
                        shift_q <= {line, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
`ifdef UART_PARITY_EN
                        if (bit_q == 3'd7) state_q <= PARITY;
`else
                        if (bit_q == 3'd7) state_q <= STOP;
`endif
                    end
`ifdef UART_PARITY_EN
                    PARITY: if (cnt_q == CENTRE) begin
                        par_q   <= line;
                        state_q <= STOP;
                    end
`endif
                    STOP: if (cnt_q == CENTRE) begin
                        rx_data_q     <= shift_q;
                        framing_err_q <= !line;
`ifdef UART_PARITY_EN
                        parity_err_q  <= ^{shift_q, par_q};
`endif
                        armed_q       <= line;
                        state_q       <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
